// File: rtl/processing_unit.sv
// 8-bit processing unit: registered single-cycle ALU plus an optional 8-step restoring divider.
// Divider present only when PU_DIVIDER_EN is defined. Divider states: IDLE | waiting for an op, BUSY | one quotient bit per clock.
module processing_unit (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  acc_data,
   input  logic [7:0]  rd_data,
   input  logic [7:0]  alu_opcode,
   input  logic        division_wakeup,
   output logic [15:0] res_out,
   output logic        z,
   output logic        ci_alu,
   output logic        done
);

   localparam logic [7:0] OP_ADD = 8'h05;
   localparam logic [7:0] OP_SUB = 8'h06;
   localparam logic [7:0] OP_MUL = 8'h07;
   localparam logic [7:0] OP_NOT = 8'h09;
   localparam logic [7:0] OP_OR  = 8'h0A;
   localparam logic [7:0] OP_XOR = 8'h0B;
   localparam logic [7:0] OP_AND = 8'h0C;
   localparam logic [7:0] OP_SHL = 8'h15;
   localparam logic [7:0] OP_SHR = 8'h16;

   logic        alu_we;
   logic [15:0] alu_res;
   logic        alu_c;

   logic        wr_en;
   logic [15:0] wr_res;
   logic        wr_c;
   logic        done_d;

   always_comb begin
      alu_we  = 1'b1;
      alu_res = '0;
      alu_c   = 1'b0;
      case (alu_opcode)
         OP_ADD: begin
            alu_res = {7'b0, {1'b0, acc_data} + {1'b0, rd_data}};
            alu_c   = alu_res[8];
         end
         OP_SUB: begin
            alu_res = {8'h00, acc_data - rd_data};
            alu_c   = (acc_data < rd_data);
         end
         OP_MUL: begin
            alu_res = 16'(acc_data) * 16'(rd_data);
            alu_c   = |alu_res[15:8];
         end
         OP_NOT: alu_res = {8'h00, ~acc_data};
         OP_OR:  alu_res = {8'h00, acc_data | rd_data};
         OP_XOR: alu_res = {8'h00, acc_data ^ rd_data};
         OP_AND: alu_res = {8'h00, acc_data & rd_data};
         OP_SHL: begin
            alu_res = {8'h00, acc_data[6:0], 1'b0};
            alu_c   = acc_data[7];
         end
         OP_SHR: begin
            alu_res = {8'h00, 1'b0, acc_data[7:1]};
            alu_c   = acc_data[0];
         end
         default: alu_we = 1'b0;
      endcase
   end

`ifdef PU_DIVIDER_EN
   localparam logic [7:0] OP_DIV = 8'h08;

   typedef enum logic {IDLE, BUSY} div_state_t;
   div_state_t state_q, state_d;

   logic [7:0] dvd_q, dvs_q, rem_q;
   logic [3:0] cnt_q;
   logic       dz_q;
   logic [8:0] rem_shl;
   logic       rem_ge;
   logic [7:0] rem_step, quo_step;
   logic       div_start, div_last;

   // A zero divisor needs no special path: every trial subtract succeeds, giving
   // quotient 0xFF and shifting the whole dividend into the remainder.
   always_comb begin
      rem_shl   = {rem_q, dvd_q[7]};
      rem_ge    = (rem_shl >= {1'b0, dvs_q});
      rem_step  = rem_ge ? 8'(rem_shl - {1'b0, dvs_q}) : rem_shl[7:0];
      quo_step  = {dvd_q[6:0], rem_ge};
      div_start = (state_q == IDLE) && (alu_opcode == OP_DIV) && division_wakeup;
      div_last  = (state_q == BUSY) && (cnt_q == 4'd1);
      state_d   = state_q;
      wr_en     = 1'b0;
      wr_res    = alu_res;
      wr_c      = alu_c;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (div_start) state_d = BUSY;
            else if (alu_we) wr_en = 1'b1;
         end
         BUSY: begin
            if (div_last) begin
               state_d = IDLE;
               wr_en   = 1'b1;
               wr_res  = {rem_step, quo_step};
               wr_c    = dz_q;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (div_start) begin
            dvd_q <= acc_data;
            dvs_q <= rd_data;
            rem_q <= '0;
            cnt_q <= 4'd8;
            dz_q  <= (rd_data == 8'h00);
         end else if (state_q == BUSY) begin
            dvd_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - 4'd1;
         end
      end
   end
`else
   logic unused_div_wakeup;
   assign unused_div_wakeup = division_wakeup;

   always_comb begin
      wr_en  = alu_we;
      wr_res = alu_res;
      wr_c   = alu_c;
      done_d = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_out <= '0;
         z       <= 1'b0;
         ci_alu  <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= done_d;
         if (wr_en) begin
            res_out <= wr_res;
            z       <= (wr_res == 16'h0000);
            ci_alu  <= wr_c;
         end
      end
   end

endmodule

// File: tb/tb_processing_unit.sv
// Self-checking bench for processing_unit: directed plan vectors plus random ops against an arithmetic model.
// Division scenarios are exercised when PU_DIVIDER_EN is defined, otherwise 0x08 is checked as a no-op.
module tb_processing_unit;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  acc_data, rd_data, alu_opcode;
   logic        division_wakeup;
   logic [15:0] res_out;
   logic        z, ci_alu, done;

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_res;
   logic        exp_z, exp_c;

   processing_unit dut (
      .clk(clk), .rstn(rstn), .acc_data(acc_data), .rd_data(rd_data),
      .alu_opcode(alu_opcode), .division_wakeup(division_wakeup),
      .res_out(res_out), .z(z), .ci_alu(ci_alu), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic wk);
      alu_opcode      = op;
      acc_data        = a;
      rd_data         = b;
      division_wakeup = wk;
   endtask

   // Reference model: results derived from plain integer arithmetic.
   task automatic model_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      int ai, bi, r;
      bit wr, c;
      ai = int'(a); bi = int'(b); r = 0; wr = 1; c = 0;
      case (int'(op))
         5:  begin r = ai + bi;               c = (r > 255); end
         6:  begin r = (ai - bi + 256) % 256; c = (ai < bi); end
         7:  begin r = ai * bi;               c = (r > 255); end
         9:  r = 255 - ai;
         10: r = int'(a | b);
         11: r = int'(a ^ b);
         12: r = int'(a & b);
         21: begin r = (ai * 2) % 256; c = (ai >= 128); end
         22: begin r = ai / 2;         c = (ai % 2 == 1); end
         default: wr = 0;
      endcase
      if (wr) begin
         exp_res = 16'(r);
         exp_c   = c;
         exp_z   = (r == 0);
      end
   endtask

   task automatic model_div(input logic [7:0] a, input logic [7:0] b);
      int q, r;
      if (b == 0) begin q = 255; r = int'(a); end
      else begin q = int'(a) / int'(b); r = int'(a) % int'(b); end
      exp_res = 16'(r * 256 + q);
      exp_c   = (b == 0);
      exp_z   = (r == 0 && q == 0);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      drive(8'h05, 8'd200, 8'd100, 1'b0);
      #12;
      if (res_out !== 16'h0000) begin errors++; $display("FAIL reset_res actual=%h expected=0000", res_out); end
      checks++;
      if (z !== 1'b0) begin errors++; $display("FAIL reset_z actual=%b expected=0", z); end
      checks++;
      if (ci_alu !== 1'b0) begin errors++; $display("FAIL reset_ci actual=%b expected=0", ci_alu); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b expected=0", done); end
      checks++;
      exp_res = '0; exp_z = 0; exp_c = 0;
      @(negedge clk);
      rstn = 1'b1;
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      tick;
   endtask

   task automatic test_arith;
      logic [7:0]  op_t[5]  = '{8'h05, 8'h06, 8'h07, 8'h05, 8'h06};
      logic [7:0]  a_t[5]   = '{8'd24, 8'd24, 8'd24, 8'd200, 8'd5};
      logic [7:0]  b_t[5]   = '{8'd78, 8'd78, 8'd78, 8'd100, 8'd5};
      logic [15:0] res_t[5] = '{16'd102, 16'h00CA, 16'd1872, 16'd300, 16'd0};
      logic        c_t[5]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0]  codes[13] = '{8'h05, 8'h06, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C,
                                 8'h15, 8'h16, 8'h00, 8'h08, 8'hFF, 8'h13};
      logic [7:0]  op, a, b;
      for (int i = 0; i < 5; i++) begin
         drive(op_t[i], a_t[i], b_t[i], 1'b0);
         tick;
         model_op(op_t[i], a_t[i], b_t[i]);
         if ({res_out, ci_alu} !== {res_t[i], c_t[i]}) begin
            errors++;
            $display("FAIL arith_plan[%0d] actual res=%0d c=%b expected res=%0d c=%b", i, res_out, ci_alu, res_t[i], c_t[i]);
         end
         checks++;
         if ({res_out, z, ci_alu, done} !== {exp_res, exp_z, exp_c, 1'b0}) begin
            errors++;
            $display("FAIL arith_model[%0d] actual=%h/%b/%b/%b expected=%h/%b/%b/0", i, res_out, z, ci_alu, done, exp_res, exp_z, exp_c);
         end
         checks++;
      end
      if (z !== 1'b1) begin errors++; $display("FAIL sub_zero_flag actual=%b expected=1", z); end
      checks++;
      for (int i = 0; i < 60; i++) begin
         op = codes[$urandom_range(0, 12)];
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         if (i % 10 == 0) b = a;
         drive(op, a, b, 1'b0);
         tick;
         model_op(op, a, b);
         if ({res_out, z, ci_alu, done} !== {exp_res, exp_z, exp_c, 1'b0}) begin
            errors++;
            $display("FAIL random_op op=%h a=%0d b=%0d actual=%h/%b/%b/%b expected=%h/%b/%b/0",
                     op, a, b, res_out, z, ci_alu, done, exp_res, exp_z, exp_c);
         end
         checks++;
      end
   endtask

   task automatic test_logic;
      logic [7:0]  op_t[8]  = '{8'h0A, 8'h0B, 8'h0C, 8'h15, 8'h16, 8'h09, 8'h15, 8'h16};
      logic [7:0]  a_t[8]   = '{8'd24, 8'd24, 8'd24, 8'd24, 8'd24, 8'h5C, 8'h81, 8'h81};
      logic [15:0] res_t[8] = '{16'd94, 16'd86, 16'd8, 16'd48, 16'd12, 16'd163, 16'd2, 16'd64};
      logic        c_t[8]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         drive(op_t[i], a_t[i], 8'd78, 1'b0);
         tick;
         model_op(op_t[i], a_t[i], 8'd78);
         if ({res_out, ci_alu, done} !== {res_t[i], c_t[i], 1'b0}) begin
            errors++;
            $display("FAIL logic_plan[%0d] actual res=%0d c=%b done=%b expected res=%0d c=%b done=0",
                     i, res_out, ci_alu, done, res_t[i], c_t[i]);
         end
         checks++;
      end
   endtask

   task automatic test_undefined;
      drive(8'h05, 8'd24, 8'd78, 1'b0);
      tick;
      model_op(8'h05, 8'd24, 8'd78);
      for (int i = 0; i < 4; i++) begin
         drive((i == 3) ? 8'h08 : 8'h00, 8'($urandom), 8'($urandom), 1'b0);
         tick;
         if ({res_out, z, ci_alu, done} !== {16'd102, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL undefined_hold[%0d] actual=%h/%b/%b/%b expected=0066/0/0/0", i, res_out, z, ci_alu, done);
         end
         checks++;
      end
   endtask

`ifdef PU_DIVIDER_EN
   task automatic test_division;
      logic [7:0]  a, b;
      logic [15:0] held_res;
      logic        held_z, held_c;
      for (int t = 0; t < 22; t++) begin
         if (t == 0)      begin a = 8'd93; b = 8'd9; end
         else if (t == 1) begin a = 8'd93; b = 8'd0; end
         else if (t == 2) begin a = 8'd0;  b = 8'd7; end
         else begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (t % 5 == 0) b = 8'd0;
         end
         drive(8'h08, a, b, 1'b1);
         tick;
         held_res = exp_res; held_z = exp_z; held_c = exp_c;
         if ({res_out, z, ci_alu, done} !== {held_res, held_z, held_c, 1'b0}) begin
            errors++;
            $display("FAIL div_start_hold[%0d] actual=%h/%b/%b/%b expected=%h/%b/%b/0", t, res_out, z, ci_alu, done, held_res, held_z, held_c);
         end
         checks++;
         for (int k = 1; k <= 8; k++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom), 8'($urandom), 1'($urandom));
            tick;
            if (k < 8) begin
               if ({res_out, z, ci_alu, done} !== {held_res, held_z, held_c, 1'b0}) begin
                  errors++;
                  $display("FAIL div_busy[%0d] cycle=%0d actual=%h/%b/%b/%b expected=%h/%b/%b/0",
                           t, k, res_out, z, ci_alu, done, held_res, held_z, held_c);
               end
               checks++;
            end else begin
               model_div(a, b);
               if ({res_out, z, ci_alu, done} !== {exp_res, exp_z, exp_c, 1'b1}) begin
                  errors++;
                  $display("FAIL div_result[%0d] a=%0d b=%0d actual=%h/%b/%b/%b expected=%h/%b/%b/1",
                           t, a, b, res_out, z, ci_alu, done, exp_res, exp_z, exp_c);
               end
               checks++;
            end
         end
         if (t == 0 && res_out !== 16'h030A) begin errors++; $display("FAIL div_plan actual=%h expected=030A", res_out); end
         if (t == 0) checks++;
         if (t == 1 && {res_out, ci_alu} !== {16'h5DFF, 1'b1}) begin
            errors++; $display("FAIL div_by_zero_plan actual=%h c=%b expected=5DFF c=1", res_out, ci_alu);
         end
         if (t == 1) checks++;
         drive(8'h00, 8'h00, 8'h00, 1'b0);
         tick;
         if ({res_out, done} !== {exp_res, 1'b0}) begin
            errors++;
            $display("FAIL div_done_pulse[%0d] actual=%h/%b expected=%h/0", t, res_out, done, exp_res);
         end
         checks++;
      end
   endtask

   task automatic test_back_to_back;
      bit exp_done;
      drive(8'h08, 8'd200, 8'd13, 1'b1);
      tick;
      for (int k = 1; k <= 17; k++) begin
         tick;
         exp_done = (k == 8 || k == 17);
         if (exp_done) model_div(8'd200, 8'd13);
         if ({res_out, z, ci_alu, done} !== {exp_res, exp_z, exp_c, exp_done}) begin
            errors++;
            $display("FAIL back_to_back cycle=%0d actual=%h/%b/%b/%b expected=%h/%b/%b/%b",
                     k, res_out, z, ci_alu, done, exp_res, exp_z, exp_c, exp_done);
         end
         checks++;
      end
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      tick;
   endtask
`else
   task automatic test_division;
      drive(8'h08, 8'd93, 8'd9, 1'b1);
      for (int k = 0; k < 12; k++) begin
         tick;
         if ({res_out, z, ci_alu, done} !== {exp_res, exp_z, exp_c, 1'b0}) begin
            errors++;
            $display("FAIL div_disabled cycle=%0d actual=%h/%b/%b/%b expected=%h/%b/%b/0",
                     k, res_out, z, ci_alu, done, exp_res, exp_z, exp_c);
         end
         checks++;
      end
      drive(8'h00, 8'h00, 8'h00, 1'b0);
   endtask
`endif

   task automatic test_reset_mid;
      drive(8'h05, 8'd200, 8'd100, 1'b0);
      tick;
      drive(8'h08, 8'd93, 8'd9, 1'b1);
      tick;
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      tick; tick; tick;
      #2 rstn = 1'b0;
      #1;
      if ({res_out, z, ci_alu, done} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_async actual=%h/%b/%b/%b expected=0000/0/0/0", res_out, z, ci_alu, done);
      end
      checks++;
      exp_res = '0; exp_z = 0; exp_c = 0;
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick;
         if ({res_out, done} !== {16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_abort cycle=%0d actual=%h/%b expected=0000/0", k, res_out, done);
         end
         checks++;
      end
   endtask

   initial begin
      test_reset;
      test_arith;
      test_logic;
      test_undefined;
      test_division;
`ifdef PU_DIVIDER_EN
      test_back_to_back;
`endif
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/processing_unit.md
Name: processing_unit

Overview:
- 8-bit integer ALU/processing unit with registered results, driven by the accumulator and register-file read data.
- Executes a one-cycle arithmetic/logic/shift operation selected by an 8-bit opcode.
- Executes a multi-cycle restoring division started by division_wakeup, signalled complete by done.
- Result is 16 bits wide so that products and quotient/remainder pairs fit.

Parameters:
- none; data width is fixed at 8 bits and result width at 16 bits.

Ports:
- clk  in  1  rising-edge system clock; the only clock.
- rstn  in  1  asynchronous, active-low reset.
- acc_data  in  8  operand A (accumulator); dividend for division.
- rd_data  in  8  operand B (register read data); divisor for division.
- alu_opcode  in  8  operation select.
- division_wakeup  in  1  division start request, level-sampled.
- res_out  out  16  registered result.
- z  out  1  registered zero flag, 1 when the new res_out == 0.
- ci_alu  out  1  registered carry/borrow/shift-out/divide-error flag.
- done  out  1  one-cycle pulse when a division result is written.

Behaviour:
- Reset (rstn=0, asynchronous): res_out=0, z=0, ci_alu=0, done=0, divider FSM=IDLE, internal divider registers cleared. Reset asserted mid-division aborts the division with no result.
- Single-cycle operations, FSM in IDLE: result registered on the rising edge where the opcode is sampled (latency 1 clock). z and ci_alu update on the same edge.
  - 0x05 ADD: res_out = {7'b0, acc+rd (9 bits)}; ci_alu = carry (bit 8).
  - 0x06 SUB: res_out = {8'h00, (acc-rd)[7:0]}; ci_alu = 1 when acc < rd (borrow).
  - 0x07 MUL: res_out = acc*rd (unsigned, 16 bits); ci_alu = 1 when the product exceeds 255.
  - 0x09 NOT: res_out = {8'h00, ~acc}; rd ignored; ci_alu = 0.
  - 0x0A OR, 0x0B XOR, 0x0C AND: res_out = {8'h00, acc op rd}; ci_alu = 0.
  - 0x15 SHL: res_out = {8'h00, acc<<1}; ci_alu = acc[7].
  - 0x16 SHR (logical): res_out = {8'h00, acc>>1}; ci_alu = acc[0].
  - Any other opcode, or 0x08 with division_wakeup=0: res_out, z and ci_alu hold their values.
- done is 0 for every single-cycle operation.
- Division (opcode 0x08), FSM states IDLE -> BUSY -> IDLE:
  - Start: in IDLE, alu_opcode==0x08 and division_wakeup==1 at edge N. Latch acc_data and rd_data, clear the partial remainder, set the iteration count to 8, enter BUSY. res_out holds.
  - BUSY: one restoring quotient bit per edge, MSB first, on edges N+1..N+8. Inputs are ignored; a new start is ignored.
  - Completion at edge N+8: res_out = {remainder[7:0], quotient[7:0]}, ci_alu = 0, z updated, done = 1 for exactly one cycle, FSM returns to IDLE.
  - A new operation may be sampled on edge N+9. If division_wakeup is still high with opcode 0x08 at that edge, a new division starts.
- Divide by zero (rd_data == 0 at start): the same 8-cycle timing applies. Result is quotient = 8'hFF, remainder = dividend, ci_alu = 1, done pulses.
- z is always computed from the value being written to res_out.

Optional Feature:
- Macro PU_DIVIDER_EN.
- Defined: the divider and the division behaviour above are present.
- Undefined: no divider logic or FSM. Opcode 0x08 behaves as an undefined opcode (outputs hold). done is tied to 0.

Test Plan:
- Reset: rstn=0 mid-operation -> res_out=0, z=0, ci_alu=0, done=0 immediately; a division in flight is aborted.
- Arithmetic, acc=24, rd=78, one clock each:
  - ADD -> res_out=102, ci_alu=0.
  - SUB -> res_out=0x00CA, ci_alu=1.
  - MUL -> res_out=1872, ci_alu=1.
  - acc=200, rd=100 ADD -> res_out=300, ci_alu=1.
  - acc=5, rd=5 SUB -> res_out=0, z=1.
- Logic and shift, acc=24, rd=78:
  - OR -> 94; XOR -> 86; AND -> 8; SHL -> 48; SHR -> 12, ci_alu=0.
  - NOT with acc=0x5C -> 163.
  - acc=0x81: SHL -> 2, ci_alu=1; SHR -> 64, ci_alu=1.
- Division: acc=93, rd=9, opcode 0x08, division_wakeup=1 for one cycle -> done pulses 8 cycles after start, res_out=0x030A (quotient 10, remainder 3).
  - Changing the inputs during BUSY has no effect on the result.
- Divide by zero: acc=93, rd=0 -> after 8 cycles res_out=0x5DFF, ci_alu=1, done=1.
- Undefined opcode 0x00 after ADD -> res_out stays 102; done never asserts outside a division.
